csr_file_m: RTL and testbench
=============================

// Module: csr_file_m
// PURPOSE
//  Machine-mode CSR file for the RV32 core: CSRRW/CSRRS/CSRRC read-modify-write, 64-bit cycle/instret counters,
//  trap entry / MRET state update and interrupt-pending output. Sits beside decode/execute.
//  The core issues one CSR op per cycle. Data reads back one cycle later. Unmapped/illegal accesses are flagged.
// PARAMETERS
//  HART_ID      0             value returned by mhartid (0xF14)
//  MTVEC_RESET  32'h0000_0000 mtvec reset value; bits[1:0] ignored (forced 0)
//  COUNTER_W    64            mcycle/minstret width; legal range 33..64; upper-half reads zero-extend
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  csr_en       in   1   CSR access valid this cycle
//  csr_op       in   2   00 read-only, 01 RW, 10 RS (set bits), 11 RC (clear bits)
//  csr_addr     in   12  CSR address
//  csr_wdata    in   32  write/mask operand
//  csr_rdata    out  32  old CSR value, registered
//  csr_illegal  out  1   registered; access was illegal
//  instret_inc  in   1   one instruction retired this cycle
//  trap_valid   in   1   take trap this cycle
//  trap_pc      in   32  PC saved to mepc
//  trap_cause   in   32  value written to mcause
//  mret         in   1   MRET executed this cycle
//  irq_ext      in   1   level machine-external interrupt (mip.MEIP)
//  mtvec_o      out  32  current mtvec
//  mepc_o       out  32  current mepc
//  irq_pending  out  1   combinational: mstatus.MIE & |(mie & mip)
// BEHAVIOUR
//  Reset (reset==0, async): every CSR = 0 except mtvec = {MTVEC_RESET[31:2],2'b0}; csr_rdata=0, csr_illegal=0.
//  Access: on posedge with csr_en=1, csr_rdata <= pre-write value; the write commits on the same edge.
//    Latency is 1 cycle. With csr_en=0, csr_rdata and csr_illegal hold their values.
//  New value: RW = wdata; RS = old|wdata; RC = old&~wdata. Op 00, or RS/RC with wdata==0, performs no write.
//  Map (WARL masks): 0x300 mstatus, only MIE[3] and MPIE[7] writable; 0x304 mie, bits 11/7/3 writable.
//    0x305 mtvec [1:0]=0; 0x340 mscratch full; 0x341 mepc [1:0]=0; 0x342 mcause full.
//    0x344 mip: MEIP[11]=irq_ext; read-only; writes ignored, not illegal.
//    0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi; all read/write.
//    0xC00/0xC80/0xC02/0xC82 read-only shadows of those counters; 0xF14 mhartid read-only.
//  Illegal: unmapped address, or a write (per rule above) to 0xCxx/0xF14. Response: csr_illegal<=1,
//    csr_rdata<=0, no state change. A legal access clears csr_illegal.
//  Counters: mcycle+1 every cycle; minstret+1 when instret_inc; wrap 2^COUNTER_W-1 -> 0.
//    A CSR write to either half replaces that half. That counter's increment is suppressed that cycle.
//    The other half is unchanged; no carry is applied.
//  Trap (trap_valid): mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
//  MRET (no trap): MIE<=MPIE, MPIE<=1.
//  Priority: trap > mret > CSR write for mstatus/mepc/mcause. A concurrent CSR read still returns the pre-edge value.
//    A CSR write to other CSRs in a trap cycle still commits.
//  Reset asserted mid-operation: immediate return to reset values; no partial update survives.
// TESTING
//  1 Reset release; read 0x305, 0x300, 0xF14 -> MTVEC_RESET&~3, 0, HART_ID; csr_illegal=0.
//  2 RW 0x340=0xDEADBEEF -> rdata 0. RS 0x340 with 0x0000_0010 -> rdata 0xDEADBEEF.
//    RC 0x340 with 0xFFFF_0000 -> rdata 0xDEADBEFF. Read -> 0x0000_BEFF.
//  3 RW 0xB00=0xFFFF_FFFE, 0xB80=0. Three idle cycles, then read 0xB80 -> 1; 0xC00 small (wrapped).
//    RW 0xC00 -> illegal, no change.
//  4 Set mie=0x800, mstatus=0x8, drive irq_ext=1 -> irq_pending=1.
//    trap_valid with pc=0x1002, cause=0x8000000B -> mepc=0x1000, MIE=0, MPIE=1, irq_pending=0.
//    Then mret -> MIE=1.
//  5 Same cycle: trap_valid + mret + RW 0x341=0x55 -> mepc=trap_pc&~3, mret ignored.
//  6 Read 0x7FF -> csr_illegal=1, rdata=0. Assert reset mid-burst of RS ops -> all CSRs at reset values.

Source files
------------

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: CSRRW/RS/RC access with one-cycle registered read data,
// cycle/instret counters, trap entry / MRET handling and interrupt-pending output.
module csr_file_m #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          COUNTER_W   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  input  logic        irq_ext,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic                 mstatus_mie_q, mstatus_mie_d;
  logic                 mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0]          mie_q, mie_d;
  logic [31:0]          mtvec_q, mtvec_d;
  logic [31:0]          mscratch_q, mscratch_d;
  logic [31:0]          mepc_q, mepc_d;
  logic [31:0]          mcause_q, mcause_d;
  logic [COUNTER_W-1:0] mcycle_q, mcycle_d;
  logic [COUNTER_W-1:0] minstret_q, minstret_d;
  logic [31:0]          csr_rdata_q, csr_rdata_d;
  logic                 csr_illegal_q, csr_illegal_d;

  logic [63:0] mcycle_ext, minstret_ext;
  logic [31:0] mip_val, old_val, new_val;
  logic        mapped, read_only, write_req, access_ok, do_write;

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);
  assign mip_val      = {20'd0, irq_ext, 11'd0};

  // Address decode and pre-write read value.
  always_comb begin
    old_val   = 32'd0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      A_MSTATUS:   old_val = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      A_MIE:       old_val = mie_q;
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MIP:       old_val = mip_val;
      A_MCYCLE:    old_val = mcycle_ext[31:0];
      A_MCYCLEH:   old_val = mcycle_ext[63:32];
      A_MINSTRET:  old_val = minstret_ext[31:0];
      A_MINSTRETH: old_val = minstret_ext[63:32];
      A_CYCLE:     begin old_val = mcycle_ext[31:0];    read_only = 1'b1; end
      A_CYCLEH:    begin old_val = mcycle_ext[63:32];   read_only = 1'b1; end
      A_INSTRET:   begin old_val = minstret_ext[31:0];  read_only = 1'b1; end
      A_INSTRETH:  begin old_val = minstret_ext[63:32]; read_only = 1'b1; end
      A_MHARTID:   begin old_val = HART_ID;             read_only = 1'b1; end
      default:     mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads and therefore legal on read-only CSRs.
  always_comb begin
    write_req = csr_en && ((csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'd0)));
    access_ok = csr_en && mapped && !(read_only && write_req);
    do_write  = access_ok && write_req;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + COUNTER_W'(1);
    minstret_d     = instret_inc ? minstret_q + COUNTER_W'(1) : minstret_q;
    csr_rdata_d    = csr_rdata_q;
    csr_illegal_d  = csr_illegal_q;

    if (csr_en) begin
      csr_rdata_d   = access_ok ? old_val : 32'd0;
      csr_illegal_d = !access_ok;
    end

    // A half-write replaces that half only and suppresses the increment.
    if (do_write) begin
      case (csr_addr)
        A_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        A_MIE:       mie_d      = new_val & MIE_MASK;
        A_MTVEC:     mtvec_d    = new_val & ALIGN_MASK;
        A_MSCRATCH:  mscratch_d = new_val;
        A_MEPC:      mepc_d     = new_val & ALIGN_MASK;
        A_MCAUSE:    mcause_d   = new_val;
        A_MCYCLE:    mcycle_d   = COUNTER_W'({mcycle_ext[63:32], new_val});
        A_MCYCLEH:   mcycle_d   = COUNTER_W'({new_val, mcycle_ext[31:0]});
        A_MINSTRET:  minstret_d = COUNTER_W'({minstret_ext[63:32], new_val});
        A_MINSTRETH: minstret_d = COUNTER_W'({new_val, minstret_ext[31:0]});
        default: ;
      endcase
    end

    // Trap and MRET override any same-cycle CSR write to the state they own.
    if (trap_valid) begin
      mepc_d         = trap_pc & ALIGN_MASK;
      mcause_d       = trap_cause;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
      csr_rdata_q    <= 32'd0;
      csr_illegal_q  <= 1'b0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
      csr_rdata_q    <= csr_rdata_d;
      csr_illegal_q  <= csr_illegal_d;
    end
  end

  assign csr_rdata   = csr_rdata_q;
  assign csr_illegal = csr_illegal_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign irq_pending = mstatus_mie_q & (|(mie_q & mip_val));

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: expected read responses are queued when an
// access is driven and compared when the registered response appears.
module tb_csr_file_m;

  localparam logic [31:0] HART  = 32'd5;
  localparam logic [31:0] MTVR  = 32'h0000_1003;
  localparam int          CW    = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_inc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic        mret;
  logic        irq_ext;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_pending;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [CW-1:0] cyc_m;

  csr_file_m #(.HART_ID(HART), .MTVEC_RESET(MTVR), .COUNTER_W(CW)) dut (
    .clk(clk), .reset(reset), .csr_en(csr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .instret_inc(instret_inc), .trap_valid(trap_valid),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret), .irq_ext(irq_ext),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Free-running reference for mcycle, valid until the first counter write.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc_m <= '0;
    else        cyc_m <= cyc_m + 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic csr_acc(input string tag, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_ill);
    logic [32:0] e;
    @(negedge clk);
    csr_en = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    exp_q.push_back({exp_ill, exp_rd});
    @(posedge clk); #1;
    csr_en = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_rdata"}, csr_rdata, e[31:0]);
    check({tag, "_ill"}, {31'd0, csr_illegal}, {31'd0, e[32]});
  endtask

  task automatic ctl_pulse(input logic trap, input logic [31:0] pc, input logic [31:0] cause,
                           input logic ret);
    @(negedge clk);
    trap_valid = trap; trap_pc = pc; trap_cause = cause; mret = ret;
    @(posedge clk); #1;
    trap_valid = 1'b0; mret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
    instret_inc = 1'b0; trap_valid = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    mret = 1'b0; irq_ext = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_ill", {31'd0, csr_illegal}, 32'h0);
    check("rst_mtvec_o", mtvec_o, 32'h0000_1000);
    check("rst_mepc_o", mepc_o, 32'h0);
    @(negedge clk); reset = 1'b1;
    csr_acc("rd_mtvec", 2'b00, 12'h305, 32'h0, 32'h0000_1000, 1'b0);
    csr_acc("rd_mstatus", 2'b00, 12'h300, 32'h0, 32'h0, 1'b0);
    csr_acc("rd_mhartid", 2'b00, 12'hF14, 32'h0, HART, 1'b0);

    // 1b: counters; mcycle low write then high write
    csr_acc("w_mcycle", 2'b01, 12'hB00, 32'hFFFF_FFFE, cyc_m[31:0], 1'b0);
    csr_acc("w_mcycleh", 2'b01, 12'hB80, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    csr_acc("rd_mcycleh", 2'b00, 12'hB80, 32'h0, 32'h1, 1'b0);
    csr_acc("rd_cycle", 2'b00, 12'hC00, 32'h0, 32'h2, 1'b0);
    csr_acc("w_cycle_ill", 2'b01, 12'hC00, 32'h5, 32'h0, 1'b1);
    csr_acc("rd_cycle2", 2'b00, 12'hC00, 32'h0, 32'h4, 1'b0);
    csr_acc("rd_cycleh", 2'b00, 12'hC80, 32'h0, 32'h1, 1'b0);

    instret_inc = 1'b1;
    repeat (5) @(posedge clk);
    #1 instret_inc = 1'b0;
    csr_acc("rd_instret", 2'b00, 12'hC02, 32'h0, 32'h5, 1'b0);
    csr_acc("w_minstreth", 2'b01, 12'hB82, 32'hFFFF_FFFF, 32'h0, 1'b0);
    csr_acc("rd_minstreth", 2'b00, 12'hB82, 32'h0, 32'h0000_00FF, 1'b0);
    csr_acc("rd_instreth", 2'b00, 12'hC82, 32'h0, 32'h0000_00FF, 1'b0);
    instret_inc = 1'b1;
    csr_acc("w_minstret_inc", 2'b01, 12'hB02, 32'd100, 32'h5, 1'b0);
    instret_inc = 1'b0;
    csr_acc("rd_minstret", 2'b00, 12'hB02, 32'h0, 32'd100, 1'b0);

    // 2: mscratch read-modify-write
    csr_acc("rw_mscratch", 2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0);
    csr_acc("rs_mscratch", 2'b10, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    csr_acc("rc_mscratch", 2'b11, 12'h340, 32'hFFFF_0000, 32'hDEAD_BEFF, 1'b0);
    csr_acc("rd_mscratch", 2'b00, 12'h340, 32'h0, 32'h0000_BEFF, 1'b0);

    // 4: interrupts, trap and mret
    csr_acc("w_mie_all", 2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0);
    csr_acc("w_mie", 2'b01, 12'h304, 32'h0000_0800, 32'h0000_0888, 1'b0);
    csr_acc("w_mstatus", 2'b01, 12'h300, 32'h0000_0008, 32'h0, 1'b0);
    check("irq_off", {31'd0, irq_pending}, 32'h0);
    irq_ext = 1'b1;
    #1 check("irq_on", {31'd0, irq_pending}, 32'h1);
    csr_acc("w_mip_ign", 2'b01, 12'h344, 32'h0, 32'h0000_0800, 1'b0);
    csr_acc("rd_mip", 2'b00, 12'h344, 32'h0, 32'h0000_0800, 1'b0);
    ctl_pulse(1'b1, 32'h0000_1002, 32'h8000_000B, 1'b0);
    check("trap_mepc_o", mepc_o, 32'h0000_1000);
    check("trap_irq", {31'd0, irq_pending}, 32'h0);
    csr_acc("trap_mstatus", 2'b00, 12'h300, 32'h0, 32'h0000_0080, 1'b0);
    csr_acc("trap_mcause", 2'b00, 12'h342, 32'h0, 32'h8000_000B, 1'b0);
    ctl_pulse(1'b0, 32'h0, 32'h0, 1'b1);
    check("mret_irq", {31'd0, irq_pending}, 32'h1);
    csr_acc("mret_mstatus", 2'b00, 12'h300, 32'h0, 32'h0000_0088, 1'b0);

    // 5: trap + mret + mepc write in one cycle
    trap_valid = 1'b1; trap_pc = 32'h0000_2007; trap_cause = 32'h7; mret = 1'b1;
    csr_acc("tmw_mepc", 2'b01, 12'h341, 32'h55, 32'h0000_1000, 1'b0);
    trap_valid = 1'b0; mret = 1'b0;
    check("tmw_mepc_o", mepc_o, 32'h0000_2004);
    csr_acc("tmw_mstatus", 2'b00, 12'h300, 32'h0, 32'h0000_0080, 1'b0);
    csr_acc("tmw_mcause", 2'b00, 12'h342, 32'h0, 32'h7, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h0000_3000; trap_cause = 32'h3;
    csr_acc("trap_w_scratch", 2'b01, 12'h340, 32'h1234, 32'h0000_BEFF, 1'b0);
    trap_valid = 1'b0;
    csr_acc("rd_scratch2", 2'b00, 12'h340, 32'h0, 32'h1234, 1'b0);
    mret = 1'b1;
    csr_acc("mret_w_mstatus", 2'b01, 12'h300, 32'h0, 32'h0, 1'b0);
    mret = 1'b0;
    csr_acc("rd_mstatus2", 2'b00, 12'h300, 32'h0, 32'h0000_0080, 1'b0);

    // 6: illegal accesses
    csr_acc("rd_unmapped", 2'b00, 12'h7FF, 32'h0, 32'h0, 1'b1);
    csr_acc("rd_hart2", 2'b00, 12'hF14, 32'h0, HART, 1'b0);
    csr_acc("w_hart_ill", 2'b01, 12'hF14, 32'h1, 32'h0, 1'b1);
    csr_acc("rs0_hart", 2'b10, 12'hF14, 32'h0, HART, 1'b0);
    csr_acc("w_mtvec", 2'b01, 12'h305, 32'h0000_2003, 32'h0000_1000, 1'b0);
    check("mtvec_o", mtvec_o, 32'h0000_2000);

    // 6b: reset in the middle of a burst of RS ops
    csr_acc("rs_b0", 2'b10, 12'h340, 32'h1, 32'h1234, 1'b0);
    csr_acc("rs_b1", 2'b10, 12'h340, 32'h2, 32'h1235, 1'b0);
    @(negedge clk);
    csr_en = 1'b1; csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 32'h4;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rdata", csr_rdata, 32'h0);
    check("mid_rst_mtvec_o", mtvec_o, 32'h0000_1000);
    check("mid_rst_mepc_o", mepc_o, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    csr_en = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    csr_acc("post_scratch", 2'b00, 12'h340, 32'h0, 32'h0, 1'b0);
    csr_acc("post_mstatus", 2'b00, 12'h300, 32'h0, 32'h0, 1'b0);
    csr_acc("post_mie", 2'b00, 12'h304, 32'h0, 32'h0, 1'b0);
    csr_acc("post_mcause", 2'b00, 12'h342, 32'h0, 32'h0, 1'b0);
    csr_acc("post_minstreth", 2'b00, 12'hB82, 32'h0, 32'h0, 1'b0);
    csr_acc("post_mtvec", 2'b00, 12'h305, 32'h0, 32'h0000_1000, 1'b0);
    check("post_irq", {31'd0, irq_pending}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
